// File: rtl/fault_detector_hls_deadlock_report_unit.sv
// Deadlock report collector for the FaultDetector dataflow region: arbitrates an origin,
// traces the token around the dependence ring, and latches a report until acknowledged.
// Optional event counter is enabled by defining FAULTDETECTOR_DL_EVENT_CNT_EN.
module fault_detector_hls_deadlock_report_unit #(
  parameter int PROC_NUM      = 4,
  parameter int ID_W          = 2,
  parameter int TRACE_TIMEOUT = 64,
  parameter int CNT_W         = 8
) (
  input  logic                reset,
  input  logic                clock,
  input  logic [PROC_NUM-1:0] dl_in_vec,
  input  logic [PROC_NUM-1:0] token_ret_vec,
  input  logic                ack,
  output logic [PROC_NUM-1:0] origin_vec,
  output logic                dl_detect_all,
  output logic                token_clear,
  output logic                dl_valid,
  output logic                dl_timeout,
  output logic [ID_W-1:0]     dl_proc_id,
  output logic [PROC_NUM-1:0] dl_chain,
  output logic [CNT_W-1:0]    dl_trace_cycles,
  output logic [CNT_W-1:0]    dl_event_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ORIGIN = 2'd1,
    TRACE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TRACE_TIMEOUT - 1);

  state_t              state;
  state_t              next_state;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    next_cnt;
  logic [PROC_NUM-1:0] next_origin_vec;
  logic                next_detect_all;
  logic                next_token_clear;
  logic                next_valid;
  logic                next_timeout;
  logic [ID_W-1:0]     next_proc_id;
  logic [PROC_NUM-1:0] next_chain;
  logic [CNT_W-1:0]    next_trace_cycles;

  function automatic logic [ID_W-1:0] lowest_index(input logic [PROC_NUM-1:0] v);
    logic [ID_W-1:0] r;
    r = '0;
    // Scan downwards so the lowest set index wins.
    for (int i = PROC_NUM - 1; i >= 0; i--) begin
      if (v[i]) begin
        r = ID_W'(i);
      end
    end
    return r;
  endfunction

  function automatic logic [PROC_NUM-1:0] onehot(input logic [ID_W-1:0] idx);
    logic [PROC_NUM-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  // Next-state and next-output computation.
  always_comb begin
    next_state        = state;
    next_cnt          = cnt;
    next_origin_vec   = '0;
    next_token_clear  = 1'b0;
    next_detect_all   = dl_detect_all;
    next_valid        = dl_valid;
    next_timeout      = dl_timeout;
    next_proc_id      = dl_proc_id;
    next_chain        = dl_chain;
    next_trace_cycles = dl_trace_cycles;
    case (state)
      IDLE: begin
        if (|dl_in_vec) begin
          next_state      = ORIGIN;
          next_proc_id    = lowest_index(dl_in_vec);
          next_origin_vec = onehot(lowest_index(dl_in_vec));
          next_detect_all = 1'b1;
        end else begin
          next_detect_all = 1'b0;
        end
      end
      ORIGIN: begin
        next_state = TRACE;
        next_chain = onehot(dl_proc_id);
        next_cnt   = '0;
      end
      TRACE: begin
        next_chain = dl_chain | token_ret_vec;
        next_cnt   = cnt + CNT_W'(1);
        // Token return outranks a coincident timeout.
        if (token_ret_vec[dl_proc_id]) begin
          next_state        = DONE;
          next_token_clear  = 1'b1;
          next_valid        = 1'b1;
          next_timeout      = 1'b0;
          next_trace_cycles = cnt + CNT_W'(1);
        end else if (cnt == TIMEOUT_LAST) begin
          next_state        = DONE;
          next_token_clear  = 1'b1;
          next_valid        = 1'b1;
          next_timeout      = 1'b1;
          next_trace_cycles = cnt + CNT_W'(1);
        end else begin
          next_state = TRACE;
        end
      end
      DONE: begin
        if (ack) begin
          next_state        = IDLE;
          next_detect_all   = 1'b0;
          next_valid        = 1'b0;
          next_timeout      = 1'b0;
          next_proc_id      = '0;
          next_chain        = '0;
          next_trace_cycles = '0;
          next_cnt          = '0;
        end else begin
          next_state = DONE;
        end
      end
      default: begin
        next_state      = IDLE;
        next_detect_all = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Registered outputs and trace counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt             <= '0;
      origin_vec      <= '0;
      dl_detect_all   <= 1'b0;
      token_clear     <= 1'b0;
      dl_valid        <= 1'b0;
      dl_timeout      <= 1'b0;
      dl_proc_id      <= '0;
      dl_chain        <= '0;
      dl_trace_cycles <= '0;
    end else begin
      cnt             <= next_cnt;
      origin_vec      <= next_origin_vec;
      dl_detect_all   <= next_detect_all;
      token_clear     <= next_token_clear;
      dl_valid        <= next_valid;
      dl_timeout      <= next_timeout;
      dl_proc_id      <= next_proc_id;
      dl_chain        <= next_chain;
      dl_trace_cycles <= next_trace_cycles;
    end
  end

`ifdef FAULTDETECTOR_DL_EVENT_CNT_EN
  logic [CNT_W-1:0] event_cnt;

  // Saturating count of arbitrated deadlock events; only reset clears it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      event_cnt <= '0;
    end else if ((state == IDLE) && (|dl_in_vec) && (event_cnt != {CNT_W{1'b1}})) begin
      event_cnt <= event_cnt + CNT_W'(1);
    end else begin
      event_cnt <= event_cnt;
    end
  end

  assign dl_event_cnt = event_cnt;
`else
  assign dl_event_cnt = '0;
`endif

endmodule

// File: doc/fault_detector_hls_deadlock_report_unit.md
Name: fault_detector_hls_deadlock_report_unit

Overview:
- Central collector downstream of the per-process deadlock detect units of the FaultDetector dataflow region.
- Consumes every unit's dl_detect_out, selects one origin process, and drives that unit's origin input.
- Traces the token as it propagates through the dependence ring, then pulses token_clear.
- Latches a deadlock report (origin id, process chain, trace latency) and holds it until software/bench acknowledges.

Parameters:
- PROC_NUM, 4, number of dataflow processes (one detect unit each).
- ID_W, 2, width of process index; must satisfy 2^ID_W >= PROC_NUM.
- TRACE_TIMEOUT, 64, max TRACE cycles before aborting with timeout flag; range 1..2^CNT_W-1.
- CNT_W, 8, width of trace-latency counter.

Ports:
- reset  in  1  asynchronous active-low reset
- clock  in  1  clock
- dl_in_vec  in  PROC_NUM  bit i = dl_detect_out of detect unit i
- token_ret_vec  in  PROC_NUM  bit i = OR of token_out_vec of unit i (unit i holds the token)
- ack  in  1  clears the latched report (effective only in DONE)
- origin_vec  out  PROC_NUM  one-hot, one-cycle origin strobe to the selected unit
- dl_detect_all  out  1  broadcast to every unit's dl_detect_in; high while not IDLE
- token_clear  out  1  one-cycle broadcast strobe
- dl_valid  out  1  report valid (state DONE)
- dl_timeout  out  1  trace ended by timeout, not token return
- dl_proc_id  out  ID_W  index of the origin process
- dl_chain  out  PROC_NUM  set of processes that held the token during trace
- dl_trace_cycles  out  CNT_W  cycles spent in TRACE
- dl_event_cnt  out  CNT_W  deadlock event counter (see Optional Feature)

Behaviour:
- All outputs are registered. Reset: state IDLE, all outputs 0, all internal registers 0.
- States: IDLE, ORIGIN, TRACE, DONE.
- IDLE: if |dl_in_vec, latch id = lowest set index, go to ORIGIN. Otherwise remain in IDLE. dl_detect_all = 0.
- ORIGIN (exactly 1 cycle): origin_vec = 1<<id; dl_chain <= 1<<id; cnt <= 0; next state TRACE.
- Timing: origin_vec is asserted the cycle after dl_in_vec is first sampled high.
- TRACE, every cycle:
  - dl_chain |= token_ret_vec; cnt increments.
  - If token_ret_vec[id] = 1: token_clear = 1 for one cycle; go to DONE with dl_timeout = 0.
  - Else if cnt == TRACE_TIMEOUT-1: token_clear = 1; go to DONE with dl_timeout = 1.
  - Token-return takes priority over timeout when both occur in the same cycle.
- DONE:
  - dl_valid = 1; report outputs are held stable.
  - On ack = 1: go to IDLE next cycle and clear dl_valid, dl_timeout, dl_chain, dl_trace_cycles and dl_proc_id.
- dl_detect_all = 1 in ORIGIN, TRACE and DONE. This freezes detect-unit dependence registers per their token rule.
- dl_in_vec changes outside IDLE are ignored. No re-arbitration occurs until return to IDLE.
- ack outside DONE is ignored. token_clear and origin_vec are never high in the same cycle.
- dl_trace_cycles = value of cnt+1 on the exit cycle (number of TRACE cycles, including the exit cycle).
- Asynchronous reset mid-operation (any state) returns immediately to IDLE with all outputs 0. Any partial report is discarded.

Optional Feature:
- Macro: FAULTDETECTOR_DL_EVENT_CNT_EN.
- Defined: dl_event_cnt increments on each IDLE->ORIGIN transition and saturates at 2^CNT_W-1. It is cleared only by reset, not by ack.
- Undefined: dl_event_cnt is tied to 0, no counter register is instantiated, and all other behaviour is identical.

Test Plan:
- Reset: hold reset = 0 with random inputs -> all outputs 0, state IDLE; release -> still all 0 while dl_in_vec = 0.
- Basic trace, PROC_NUM = 4: dl_in_vec = 4'b0100 at cycle 0 -> origin_vec = 4'b0100 at cycle 1. Then token_ret_vec = 0010 (c2), 1000 (c3), 0100 (c4) -> token_clear at c4 exit, dl_valid = 1, dl_proc_id = 2, dl_chain = 4'b1110, dl_trace_cycles = 3, dl_timeout = 0.
- Priority: dl_in_vec = 4'b1010 -> dl_proc_id = 1, origin_vec = 4'b0010. A dl_in_vec change to 4'b0001 during TRACE -> no effect.
- Timeout: TRACE_TIMEOUT = 8, token never returns -> token_clear after 8 TRACE cycles, dl_timeout = 1, dl_trace_cycles = 8.
- Ack and event count: ack in TRACE -> ignored; ack in DONE -> IDLE next cycle, report cleared, dl_detect_all = 0. Two full events with the macro defined -> dl_event_cnt = 2; with it undefined -> 0.
- Reset mid-TRACE: drop reset during TRACE -> outputs 0 asynchronously; after release, a new dl_in_vec = 4'b0001 -> normal sequence with dl_chain starting at 4'b0001.
